// File: rtl/game_pkg.sv
// Shared encodings for the fire/gold grid game: game states, scheduler
// states, default timing and the difficulty period helper.
package game_pkg;

    localparam logic [1:0] GS_INIT   = 2'b00;
    localparam logic [1:0] GS_PLAY   = 2'b01;
    localparam logic [1:0] GS_FINISH = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_WAIT_ACK
    } sched_state_e;

    localparam int unsigned DEF_BASE_PERIOD     = 32'd67108864;
    localparam int unsigned DEF_STEP_DEC        = 32'd8388608;
    localparam int unsigned DEF_MIN_PERIOD      = 32'd16777216;
    localparam int unsigned DEF_WARN_LEAD       = 32'd16777216;
    localparam int unsigned DEF_GOLD_EVERY      = 32'd3;
    localparam int unsigned DEF_SCORE_PER_LEVEL = 32'd2;
    localparam int unsigned DEF_LEVEL_MAX       = 32'd3;

    // Wide product so a large level*step can never wrap below the floor.
    function automatic logic [31:0] calc_period(
        input logic [31:0] base,
        input logic [31:0] step,
        input logic [31:0] min_p,
        input logic [1:0]  lvl
    );
        logic [33:0] dec;
        logic [31:0] p;
        dec = 34'(step) * 34'(lvl);
        if (dec >= 34'(base)) p = min_p;
        else                  p = base - dec[31:0];
        if (p < min_p) p = min_p;
        return p;
    endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// Game-controller side bundle of the tick scheduler: game inputs,
// collision-check handshake and timing strobes.
interface tick_scheduler_if;

    logic [1:0] game_state;
    logic [3:0] score;
    logic       pause;
    logic       chk_ack;
    logic       fire_tick;
    logic       gold_tick;
    logic       chk_req;
    logic       warn;
    logic [1:0] level;
    logic [7:0] tick_cnt;

    modport master (
        output game_state, score, pause, chk_ack,
        input  fire_tick, gold_tick, chk_req, warn, level, tick_cnt
    );

    modport slave (
        input  game_state, score, pause, chk_ack,
        output fire_tick, gold_tick, chk_req, warn, level, tick_cnt
    );

endinterface

// File: rtl/tick_countdown.sv
// Loadable down-counter that holds at zero or when not enabled;
// load has priority over decrement.
module tick_countdown #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_dec && (r_count != '0))
            r_count <= r_count - W'(1);
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/tick_scheduler.sv
// Fire/gold tick scheduler with collision-check handshake and pause.
// Define DIFFICULTY_RAMP_EN to let the level (and period) follow score.
module tick_scheduler
    import game_pkg::*;
#(
    parameter int unsigned BASE_PERIOD     = DEF_BASE_PERIOD,
    parameter int unsigned STEP_DEC        = DEF_STEP_DEC,
    parameter int unsigned MIN_PERIOD      = DEF_MIN_PERIOD,
    parameter int unsigned WARN_LEAD       = DEF_WARN_LEAD,
    parameter int unsigned GOLD_EVERY      = DEF_GOLD_EVERY,
    parameter int unsigned SCORE_PER_LEVEL = DEF_SCORE_PER_LEVEL,
    parameter int unsigned LEVEL_MAX       = DEF_LEVEL_MAX
) (
    input logic             clk,
    input logic             rst,
    tick_scheduler_if.slave io_bus
);

    sched_state_e r_state;
    sched_state_e w_state_nxt;

    logic        r_fire;
    logic        r_gold;
    logic [3:0]  r_gold_cnt;
    logic [7:0]  r_tick_cnt;
    logic [1:0]  r_level;

    logic        w_fire_nxt;
    logic        w_gold_nxt;
    logic [3:0]  w_gold_cnt_nxt;
    logic [7:0]  w_tick_cnt_nxt;
    logic [1:0]  w_level_nxt;
    logic [1:0]  w_lvl_new;
    logic [31:0] w_period0;
    logic [31:0] w_period_new;

    logic        w_play;
    logic        w_cd_load;
    logic [31:0] w_cd_val;
    logic        w_cd_dec;
    logic [31:0] w_cd_count;
    logic        w_cd_zero;

    assign w_play = (io_bus.game_state == GS_PLAY);

`ifdef DIFFICULTY_RAMP_EN
    logic [31:0] w_lvl_div;

    assign w_lvl_div    = 32'(io_bus.score) / SCORE_PER_LEVEL;
    assign w_lvl_new    = (w_lvl_div > LEVEL_MAX) ? 2'(LEVEL_MAX)
                                                  : w_lvl_div[1:0];
    assign w_period0    = calc_period(BASE_PERIOD, STEP_DEC,
                                      MIN_PERIOD, 2'd0);
    assign w_period_new = calc_period(BASE_PERIOD, STEP_DEC,
                                      MIN_PERIOD, w_lvl_new);
`else
    logic w_unused_ramp;

    assign w_unused_ramp = ^{io_bus.score, STEP_DEC, MIN_PERIOD,
                             SCORE_PER_LEVEL, LEVEL_MAX};
    assign w_lvl_new     = 2'd0;
    assign w_period0     = BASE_PERIOD;
    assign w_period_new  = BASE_PERIOD;
`endif

    tick_countdown #(
        .W (32)
    ) u_countdown (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cd_load),
        .i_load_val (w_cd_val),
        .i_dec      (w_cd_dec),
        .o_count    (w_cd_count),
        .o_zero     (w_cd_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Leaving PLAY clears the game from any state; otherwise the tick edge
    // samples the level and reloads with the period of that level.
    always_comb begin
        w_state_nxt    = r_state;
        w_fire_nxt     = 1'b0;
        w_gold_nxt     = 1'b0;
        w_gold_cnt_nxt = r_gold_cnt;
        w_tick_cnt_nxt = r_tick_cnt;
        w_level_nxt    = r_level;
        w_cd_load      = 1'b0;
        w_cd_val       = '0;
        w_cd_dec       = 1'b0;
        if (!w_play) begin
            w_state_nxt    = ST_IDLE;
            w_gold_cnt_nxt = '0;
            w_tick_cnt_nxt = '0;
            w_level_nxt    = '0;
            w_cd_load      = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_RUN;
                    w_cd_load   = 1'b1;
                    w_cd_val    = w_period0 - 32'd1;
                end
                ST_RUN: begin
                    if (io_bus.pause) begin
                        w_state_nxt = ST_PAUSED;
                    end else if (w_cd_zero) begin
                        w_state_nxt = ST_WAIT_ACK;
                        w_fire_nxt  = 1'b1;
                        w_level_nxt = w_lvl_new;
                        w_cd_load   = 1'b1;
                        w_cd_val    = w_period_new - 32'd1;
                        if (r_tick_cnt != 8'hFF)
                            w_tick_cnt_nxt = r_tick_cnt + 8'd1;
                        if ((r_gold_cnt + 4'd1) == 4'(GOLD_EVERY)) begin
                            w_gold_nxt     = 1'b1;
                            w_gold_cnt_nxt = '0;
                        end else begin
                            w_gold_cnt_nxt = r_gold_cnt + 4'd1;
                        end
                    end else begin
                        w_cd_dec = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!io_bus.pause) w_state_nxt = ST_RUN;
                end
                ST_WAIT_ACK: begin
                    if (io_bus.chk_ack)
                        w_state_nxt = io_bus.pause ? ST_PAUSED : ST_RUN;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fire     <= 1'b0;
            r_gold     <= 1'b0;
            r_gold_cnt <= '0;
            r_tick_cnt <= '0;
            r_level    <= '0;
        end else begin
            r_fire     <= w_fire_nxt;
            r_gold     <= w_gold_nxt;
            r_gold_cnt <= w_gold_cnt_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_level    <= w_level_nxt;
        end
    end

    assign io_bus.fire_tick = r_fire;
    assign io_bus.gold_tick = r_gold;
    assign io_bus.chk_req   = (r_state == ST_WAIT_ACK);
    assign io_bus.warn      = (r_state == ST_RUN) && (w_cd_count < WARN_LEAD);
    assign io_bus.level     = r_level;
    assign io_bus.tick_cnt  = r_tick_cnt;

endmodule
